// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the register file's single write port between two writers:
//   - port A: core writeback, single cycle, never back-pressured
//   - port B: long-latency results (mul/div, load miss), valid/ready handshake
// B results are held in a small in-order FIFO and drained into write slots
// that A leaves free. If the FIFO head is denied MAX_WAIT consecutive cycles,
// it is forced through and the core is stalled for that cycle. Pending flags
// report whether a decode source register is still waiting in the FIFO.
//
// Ports:
//   clk                    system clock, rising edge
//   rst                    asynchronous active-high reset
//   a_we, a_rd, a_data     core writeback request
//   b_valid, b_rd, b_data  long-latency result, b_ready = FIFO can accept
//   rs1, rs2               decode source registers
//   rs1_pend, rs2_pend     source register targeted by a queued B entry
//   core_stall             core must hold its current instruction
//   rf_we, rf_rd, rf_wdata register file write port
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_we,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_pend,
  output logic        rs2_pend,
  output logic        core_stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  // FIFO storage and control state
  logic [4:0]    mem_rd_q   [DEPTH];
  logic [4:0]    mem_rd_d   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;

  logic empty_s;
  logic full_s;
  logic force_s;
  logic grant_a_s;
  logic grant_b_s;
  logic push_s;
  logic pop_s;

  assign empty_s = (count_q == {CW{1'b0}});
  assign full_s  = (count_q == FULL_CNT);
  assign force_s = !empty_s && (wait_cnt_q >= WAIT_MAX);

  // Entries for x0 are consumed by the handshake but never stored.
  assign push_s  = b_valid && b_ready && (b_rd != 5'd0);
  assign pop_s   = grant_b_s;
  assign b_ready = !full_s && !rst;

  // Write-port grant and output mux. A write to x0 leaves the slot free for B.
  always_comb begin
    grant_a_s  = 1'b0;
    grant_b_s  = 1'b0;
    core_stall = 1'b0;
    rf_we      = 1'b0;
    rf_rd      = 5'd0;
    rf_wdata   = 32'd0;
    if (rst) begin
      grant_a_s = 1'b0;
    end else if (force_s) begin
      grant_b_s  = 1'b1;
      core_stall = 1'b1;
    end else if (a_we && (a_rd != 5'd0)) begin
      grant_a_s = 1'b1;
    end else if (!empty_s) begin
      grant_b_s = 1'b1;
    end else begin
      grant_b_s = 1'b0;
    end

    if (grant_a_s) begin
      rf_we    = 1'b1;
      rf_rd    = a_rd;
      rf_wdata = a_data;
    end else if (grant_b_s) begin
      rf_we    = 1'b1;
      rf_rd    = mem_rd_q[rd_ptr_q];
      rf_wdata = mem_data_q[rd_ptr_q];
    end else begin
      rf_we    = 1'b0;
    end
  end

  // Pending flags: compare decode sources against every live FIFO entry.
  always_comb begin
    logic [PW-1:0] off;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    off      = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      // Distance from the head decides whether slot i holds a live entry.
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        if ((rs1 != 5'd0) && (mem_rd_q[i] == rs1)) begin
          rs1_pend = 1'b1;
        end else begin
          rs1_pend = rs1_pend;
        end
        if ((rs2 != 5'd0) && (mem_rd_q[i] == rs2)) begin
          rs2_pend = 1'b1;
        end else begin
          rs2_pend = rs2_pend;
        end
      end else begin
        off = off;
      end
    end
  end

  // FIFO next state: storage write, pointers and occupancy.
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_s) begin
      mem_rd_d[wr_ptr_q]   = b_rd;
      mem_data_d[wr_ptr_q] = b_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation counter: counts consecutive denied cycles of a non-empty FIFO.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (empty_s || grant_b_s) begin
      wait_cnt_d = {WW{1'b0}};
    end else if (wait_cnt_q < WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Control registers; reset discards every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      wait_cnt_q <= {WW{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Payload storage; contents are only meaningful while counted as live.
  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_we;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  logic        b_ready, rs1_pend, rs2_pend, core_stall, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  logic        b_ready16, rs1_pend16, rs2_pend16, core_stall16, rf_we16;
  logic [4:0]  rf_rd16;
  logic [31:0] rf_wdata16;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic        a_we;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        exp_we;
  } vec_t;
  vec_t vecs[5];

  rf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) u_dut (
    .clk(clk), .rst(rst), .a_we(a_we), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rs1(rs1), .rs2(rs2), .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
    .core_stall(core_stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  rf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .a_we(a_we), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready16), .b_rd(b_rd), .b_data(b_data),
    .rs1(rs1), .rs2(rs2), .rs1_pend(rs1_pend16), .rs2_pend(rs2_pend16),
    .core_stall(core_stall16), .rf_we(rf_we16), .rf_rd(rf_rd16), .rf_wdata(rf_wdata16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Scoreboard: every write on the main instance must match the next expectation.
  always @(negedge clk) begin
    if (mon_en && !rst && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual rd=%0d data=%h expected none", rf_rd, rf_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if (rf_rd !== w.rd || rf_wdata !== w.data) begin
          errors++;
          $display("FAIL write_order actual rd=%0d data=%h expected rd=%0d data=%h",
                   rf_rd, rf_wdata, w.rd, w.data);
        end
      end
    end
  end

  initial begin
    int k;
    vecs[0] = '{1'b1, 5'd5,  32'hABCD1234, 1'b1};
    vecs[1] = '{1'b1, 5'd0,  32'h0BAD0BAD, 1'b0};
    vecs[2] = '{1'b0, 5'd7,  32'h77777777, 1'b0};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1};

    rst = 1'b1; a_we = 1'b0; a_rd = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0; rs1 = 5'd0; rs2 = 5'd0;
    repeat (2) step();
    mid();
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_b_ready", {31'd0, b_ready}, 32'd0);
    chk("reset_stall", {31'd0, core_stall}, 32'd0);
    step();
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset while two B entries are queued
    a_we = 1'b1; a_rd = 5'd20; a_data = 32'h20202020;
    b_valid = 1'b1; b_rd = 5'd11; b_data = 32'h11111111;
    rs1 = 5'd11; rs2 = 5'd12;
    push_exp(5'd20, 32'h20202020);
    mid();
    chk("t1_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    a_rd = 5'd21; a_data = 32'h21212121; b_rd = 5'd12; b_data = 32'h12121212;
    push_exp(5'd21, 32'h21212121);
    mid();
    chk("t1_rs1_pend_before", {31'd0, rs1_pend}, 32'd1);
    step();
    rst = 1'b1; a_we = 1'b0; b_valid = 1'b0;
    mid();
    chk("t1_rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("t1_rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("t1_rst_stall", {31'd0, core_stall}, 32'd0);
    chk("t1_rst_rs1_pend", {31'd0, rs1_pend}, 32'd0);
    chk("t1_rst_rs2_pend", {31'd0, rs2_pend}, 32'd0);
    step();
    rst = 1'b0;
    mid();
    chk("t1_post_b_ready", {31'd0, b_ready}, 32'd1);
    chk("t1_post_rf_we", {31'd0, rf_we}, 32'd0);
    chk("t1_post_rs1_pend", {31'd0, rs1_pend}, 32'd0);
    step();
    mid();
    chk("t1_post_rf_we2", {31'd0, rf_we}, 32'd0);
    step();

    // Table: A-only writes with the FIFO empty
    for (int i = 0; i < 5; i++) begin
      a_we = vecs[i].a_we; a_rd = vecs[i].a_rd; a_data = vecs[i].a_data;
      if (vecs[i].exp_we) push_exp(vecs[i].a_rd, vecs[i].a_data);
      mid();
      chk($sformatf("vec%0d_rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_stall", i), {31'd0, core_stall}, 32'd0);
      step();
    end
    a_we = 1'b0;

    // Single B result, no bypass, pend flag lifetime
    rs1 = 5'd0; rs2 = 5'd10;
    b_valid = 1'b1; b_rd = 5'd10; b_data = 32'h12345678;
    mid();
    chk("t3_no_bypass", {31'd0, rf_we}, 32'd0);
    chk("t3_pend_n", {31'd0, rs2_pend}, 32'd0);
    push_exp(5'd10, 32'h12345678);
    step();
    b_valid = 1'b0;
    mid();
    chk("t3_rf_we_n1", {31'd0, rf_we}, 32'd1);
    chk("t3_pend_n1", {31'd0, rs2_pend}, 32'd1);
    step();
    mid();
    chk("t3_pend_n2", {31'd0, rs2_pend}, 32'd0);
    chk("t3_idle_n2", {31'd0, rf_we}, 32'd0);
    step();
    rs2 = 5'd0;

    // Starvation: forced drain after four denied cycles
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hDEADBEEF;
    step();
    b_valid = 1'b0;
    k = 1;
    for (int c = 0; c < 9; c++) begin
      a_we = 1'b1; a_rd = k[4:0]; a_data = 32'hA0000000 + k;
      if (c == 4) push_exp(5'd7, 32'hDEADBEEF);
      else        push_exp(k[4:0], 32'hA0000000 + k);
      mid();
      chk($sformatf("t4_stall_c%0d", c), {31'd0, core_stall}, (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) chk("t4_forced_rd", {27'd0, rf_rd}, 32'd7);
      if (c != 4) k++;
      step();
    end
    a_we = 1'b0;
    mid();
    chk("t4_queue_drained", exp_q.size(), 32'd0);
    step();

    // Full FIFO backpressure on the MAX_WAIT=16 instance
    mon_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_we = 1'b1; a_rd = 5'd20; a_data = 32'h00000020;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h33333333;
    mid();
    chk("t5_ready_c0", {31'd0, b_ready16}, 32'd1);
    step();
    a_rd = 5'd21; b_rd = 5'd4; b_data = 32'h44444444;
    mid();
    chk("t5_ready_c1", {31'd0, b_ready16}, 32'd1);
    step();
    a_rd = 5'd22; b_rd = 5'd6; b_data = 32'h66666666;
    mid();
    chk("t5_full_c2", {31'd0, b_ready16}, 32'd0);
    chk("t5_a_wins_c2", {27'd0, rf_rd16}, 32'd22);
    step();
    a_rd = 5'd23;
    mid();
    chk("t5_full_c3", {31'd0, b_ready16}, 32'd0);
    step();
    a_we = 1'b0;
    mid();
    chk("t5_drain_rd3", {27'd0, rf_rd16}, 32'd3);
    chk("t5_drain_data3", rf_wdata16, 32'h33333333);
    chk("t5_full_c4", {31'd0, b_ready16}, 32'd0);
    step();
    mid();
    chk("t5_ready_back", {31'd0, b_ready16}, 32'd1);
    chk("t5_drain_rd4", {27'd0, rf_rd16}, 32'd4);
    step();
    b_valid = 1'b0;
    mid();
    chk("t5_drain_rd6_we", {31'd0, rf_we16}, 32'd1);
    chk("t5_drain_rd6", {27'd0, rf_rd16}, 32'd6);
    step();
    mid();
    chk("t5_idle", {31'd0, rf_we16}, 32'd0);
    step();

    // x0 writes: A slot freed for B; b_rd=0 dropped
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99999999;
    step();
    b_valid = 1'b0;
    a_we = 1'b1; a_rd = 5'd0; a_data = 32'h55555555;
    push_exp(5'd9, 32'h99999999);
    mid();
    chk("t6_rf_we", {31'd0, rf_we}, 32'd1);
    chk("t6_rf_rd", {27'd0, rf_rd}, 32'd9);
    chk("t6_stall", {31'd0, core_stall}, 32'd0);
    step();
    a_we = 1'b0;
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h0BADF00D;
    mid();
    chk("t6_zero_ready", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    mid();
    chk("t6_zero_no_write", {31'd0, rf_we}, 32'd0);
    chk("t6_zero_no_pend", {31'd0, rs1_pend}, 32'd0);
    step();
    mid();
    chk("t6_zero_no_write2", {31'd0, rf_we}, 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writers:
  - Port A: core writeback, single-cycle, no backpressure.
  - Port B: long-latency unit (mul/div, load miss), valid/ready handshake.
- B results are buffered in a small FIFO and drained into free write slots.
- A starvation counter forces a B drain by stalling the core.
- Pending-register flags let the core's hazard logic hold reads and writes to registers still waiting in the FIFO.

Parameters:
- DEPTH, 2, B FIFO entries; power of two, at least 2.
- MAX_WAIT, 4, consecutive denied cycles before the FIFO head is forced through.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- a_we  in  1  core writeback request
- a_rd  in  5  core destination register
- a_data  in  32  core write data
- b_valid  in  1  long-latency result valid
- b_ready  out  1  FIFO can accept a B result
- b_rd  in  5  B destination register
- b_data  in  32  B write data
- rs1  in  5  core source register 1 under decode
- rs2  in  5  core source register 2 under decode
- rs1_pend  out  1  rs1 is targeted by a queued B entry
- rs2_pend  out  1  rs2 is targeted by a queued B entry
- core_stall  out  1  core must hold its current instruction this cycle
- rf_we  out  1  register file write_enable
- rf_rd  out  5  register file rd
- rf_wdata  out  32  register file write_data

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous and active-high.
  - While rst=1: FIFO pointers, count and wait_cnt clear; rf_we=0, b_ready=0, core_stall=0, rs1_pend=0, rs2_pend=0.
  - Reset mid-operation discards all queued entries without writing them.
- FIFO:
  - b_ready = !full && !rst.
  - A B result is accepted on a rising edge when b_valid && b_ready.
  - An accepted entry with b_rd=0 is dropped: not enqueued, not pending.
  - No same-cycle bypass; an entry is eligible to write from the cycle after acceptance.
  - The FIFO drains in order; there is no reordering among B entries.
- Grant (combinational from registered state and A inputs), evaluated in priority order:
  1. force = FIFO non-empty && wait_cnt >= MAX_WAIT. Grant the B head and assert core_stall=1; A's write is suppressed this cycle. The core holds a_we/a_rd/a_data and re-presents them next cycle.
  2. Otherwise, if a_we && a_rd!=0, grant A.
  3. Otherwise, if the FIFO is non-empty, grant the B head.
  4. Otherwise, rf_we=0. rf_rd and rf_wdata are don't-care; drive 0.
- Writes to x0:
  - a_we with a_rd=0 never asserts rf_we.
  - The slot is treated as free, so a B head may use it.
- Dequeue: the head pops on the rising edge of any cycle where B is granted; the write and the pop occur on the same edge.
- Starvation counter:
  - wait_cnt increments (saturating at MAX_WAIT) on each edge where the FIFO is non-empty and B is not granted.
  - It clears on any edge where B is granted or the FIFO is empty.
  - Width is clog2(MAX_WAIT+1).
  - After a forced grant the counter clears, so the next head starts fresh.
- Simultaneous events:
  - An enqueue and a dequeue on the same edge are legal whenever not full; count is unchanged.
  - When full, b_ready=0, so no enqueue is possible that cycle even if a dequeue occurs.
- Pending flags:
  - rsN_pend = rsN!=0 && some valid FIFO entry has rd==rsN.
  - Flags are combinational over the FIFO contents.
  - They deassert the cycle after the matching entry is written.
  - The core treats pend=1 as a RAW hazard (stall the read) and a WAW hazard (do not issue an A write to that rd).
  - The arbiter itself performs no ordering check between A and B.

Test Plan:
1. Assert rst while two B entries are queued → rf_we=0, b_ready=0, core_stall=0, both pend flags 0. After release, b_ready=1 and the discarded entries are never written.
2. a_we=1, a_rd=5, a_data=ABCD1234, FIFO empty → same cycle rf_we=1, rf_rd=5, rf_wdata=ABCD1234, core_stall=0.
3. b_valid=1, b_rd=10, b_data=12345678 accepted at edge N, A idle → rf_we=1, rf_rd=10, rf_wdata=12345678 in cycle N+1. With rs2=10, rs2_pend=1 in cycle N+1 and 0 in N+2.
4. One B entry (rd=7, data=DEADBEEF) queued; A writes rd=1..8 every cycle → B denied 4 cycles, then core_stall=1 with rf_rd=7, rf_wdata=DEADBEEF. The held A write (rd=5) lands the next cycle.
5. A writing continuously (MAX_WAIT raised to 16); push rd=3 then rd=4 → b_ready=0 after the second accept, and a third b_valid (rd=6) is held. Once A goes idle, rd=3 is written, b_ready returns to 1, and rd=6 is accepted on that edge.
6. a_we=1, a_rd=0 with B head rd=9 queued → rf_we=1, rf_rd=9 (B uses the slot). A separate b_rd=0 accept leaves count unchanged and is never written.
